// File: rtl/msrv32_pc_unit.sv
// Program counter unit for the MSRV32 core: boot sequencing, next-PC
// selection (trap > mret > taken branch > sequential), fetch address
// generation and pipeline flush indication.
module msrv32_pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             ahb_ready_in,
  input  logic             branch_taken_in,
  input  logic [4:0]       opcode_6_to_2_in,
  input  logic [WIDTH-1:0] rs1_in,
  input  logic [WIDTH-1:0] imm_in,
  input  logic             trap_taken_in,
  input  logic [WIDTH-1:0] trap_address_in,
  input  logic             mret_in,
  input  logic [WIDTH-1:0] epc_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_4_out,
  output logic [WIDTH-1:0] iaddr_out,
  output logic             misaligned_instr_out,
  output logic             flush_out
);

  typedef enum logic [1:0] {
    RST  = 2'd0,
    BOOT = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] next_pc;
  logic             redirect;
  logic             is_cti;
  logic [WIDTH-1:0] pc_next;
  logic             flush_next;

  assign pc_plus_4_out = pc_out + WIDTH'(4);

  assign is_cti = (opcode_6_to_2_in == OP_BRANCH) ||
                  (opcode_6_to_2_in == OP_JAL)    ||
                  (opcode_6_to_2_in == OP_JALR);

  // Branch/jump target: PC-relative, or register-relative with bit 0 cleared for JALR
  always_comb begin
    jump_target = '0;
    if (opcode_6_to_2_in == OP_JALR) begin
      jump_target    = rs1_in + imm_in;
      jump_target[0] = 1'b0;
    end else begin
      jump_target = pc_out + imm_in;
    end
  end

  assign misaligned_instr_out = branch_taken_in & is_cti & jump_target[1];

  // Next-PC priority select; while the current instruction is flushed only a trap may redirect
  always_comb begin
    next_pc  = pc_plus_4_out;
    redirect = 1'b0;
    if (trap_taken_in) begin
      next_pc  = trap_address_in;
      redirect = 1'b1;
    end else if (!flush_out && mret_in) begin
      next_pc  = epc_in;
      redirect = 1'b1;
    end else if (!flush_out && branch_taken_in && !misaligned_instr_out) begin
      next_pc  = jump_target;
      redirect = 1'b1;
    end
  end

  // State register
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state <= RST;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, fetch address and PC/flush update values
  always_comb begin
    state_next = state;
    iaddr_out  = BOOT_ADDRESS;
    pc_next    = pc_out;
    flush_next = flush_out;
    case (state)
      RST: begin
        state_next = BOOT;
      end
      BOOT: begin
        if (ahb_ready_in) begin
          state_next = RUN;
          pc_next    = BOOT_ADDRESS;
          flush_next = 1'b0;
        end
      end
      RUN: begin
        iaddr_out = {next_pc[WIDTH-1:2], 2'b00};
        if (ahb_ready_in) begin
          pc_next    = next_pc;
          flush_next = redirect;
        end
      end
      default: begin
        state_next = RST;
      end
    endcase
  end

  // PC and flush registers; reset overrides any stall or redirect
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      pc_out    <= BOOT_ADDRESS;
      flush_out <= 1'b1;
    end else begin
      pc_out    <= pc_next;
      flush_out <= flush_next;
    end
  end

endmodule

// File: doc/msrv32_pc_unit.md
MSRV32_PC_UNIT -- requirements
Module: msrv32_pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width.
REQ-002 SHALL have parameter BOOT_ADDRESS, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have port ms_riscv32_mp_clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port ms_riscv32_mp_rst_in  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port ahb_ready_in  input  1  fetch bus ready; 0 = stall, all state held.
REQ-006 SHALL have port branch_taken_in  input  1  branch/jump decision from branch unit.
REQ-007 SHALL have port opcode_6_to_2_in  input  5  opcode[6:2] of instruction at pc_out.
REQ-008 SHALL have port rs1_in  input  WIDTH  rs1 value, used for JALR.
REQ-009 SHALL have port imm_in  input  WIDTH  sign-extended immediate.
REQ-010 SHALL have port trap_taken_in  input  1  trap request from CSR unit.
REQ-011 SHALL have port trap_address_in  input  WIDTH  trap vector target.
REQ-012 SHALL have port mret_in  input  1  return from trap.
REQ-013 SHALL have port epc_in  input  WIDTH  mret return address.
REQ-014 SHALL have port pc_out  output  WIDTH  registered PC of instruction in execute.
REQ-015 SHALL have port pc_plus_4_out  output  WIDTH  pc_out + 4, combinational.
REQ-016 SHALL have port iaddr_out  output  WIDTH  fetch address, bits[1:0] forced 0.
REQ-017 SHALL have port misaligned_instr_out  output  1  taken target not 4-byte aligned, combinational.
REQ-018 SHALL have port flush_out  output  1  registered; 1 = instruction at pc_out invalid, treat as NOP.

Function
REQ-019 SHALL implement FSM states RST, BOOT, RUN.
- RST: whenever ms_riscv32_mp_rst_in=1; next state BOOT.
- BOOT: iaddr_out=BOOT_ADDRESS, pc_out held, flush_out=1; moves to RUN when ahb_ready_in=1, else stays.
- RUN: normal operation; leaves only via reset.
REQ-020 SHALL compute the branch target as follows.
- opcode 11000 (BRANCH) or 11011 (JAL): pc_out + imm_in.
- opcode 11001 (JALR): (rs1_in + imm_in) with bit0 cleared.
- All additions modulo 2^WIDTH; carry discarded.
REQ-021 SHALL assert misaligned_instr_out = branch_taken_in AND target[1]=1, and only when opcode is 11000, 11011 or 11001.
REQ-022 SHALL select next_pc in RUN by fixed priority.
- trap_taken_in → trap_address_in.
- else mret_in → epc_in.
- else branch_taken_in AND NOT misaligned → target.
- else pc_out + 4.
REQ-023 SHALL drive iaddr_out = next_pc in RUN with bits[1:0]=0.
REQ-024 SHALL load pc_out with next_pc in RUN when ahb_ready_in=1; on BOOT→RUN, pc_out <= BOOT_ADDRESS.
REQ-025 SHALL set flush_out as follows.
- In RUN with ahb_ready_in=1: 1 on the next edge when the selected source was trap, mret or taken branch; otherwise 0.
- When ahb_ready_in=0: held.
- On BOOT→RUN: 0.
REQ-026 SHALL ignore branch_taken_in, trap_taken_in and mret_in while flush_out=1, except trap_taken_in; next_pc = pc_out + 4 in that case.
REQ-027 SHALL, when misaligned, suppress the redirect and fetch pc_out+4; the CSR unit raises the trap on a later cycle.

Reset
REQ-028 SHALL, on a reset edge, set state=RST, pc_out=BOOT_ADDRESS and flush_out=1; reset mid-stall or mid-redirect overrides everything.
REQ-029 SHALL drive iaddr_out=BOOT_ADDRESS while in RST or BOOT.

Verification
REQ-030 SHALL verify boot: reset 2 cycles, ahb_ready_in=1 → iaddr_out 0x0 in BOOT, then 0x4; pc_out 0x0 with flush_out=0 in first RUN cycle.
REQ-031 SHALL verify BEQ taken: pc_out=0x100, opcode 11000, imm=0x20, branch_taken_in=1 → iaddr_out 0x120; next cycle pc_out=0x120, flush_out=1.
REQ-032 SHALL verify JALR: rs1=0x203, imm=0x4, opcode 11001 → target 0x206, misaligned_instr_out=1, iaddr_out=pc_out+4.
REQ-033 SHALL verify priority: trap_taken_in=1, mret_in=1, branch taken simultaneously, trap_address_in=0x80 → iaddr_out 0x80.
REQ-034 SHALL verify stall: ahb_ready_in=0 for 3 cycles after a redirect → pc_out and flush_out unchanged until ready returns.
REQ-035 SHALL verify reset mid-run: reset asserted at pc_out=0x300 → next edge pc_out=0x0, flush_out=1, state BOOT after release.
